float_copro_arbiter: RTL
========================

# float_copro_arbiter

Round-robin arbiter and sequencer that shares one float_pack arithmetic unit (add, sub, mul) between two requesters of the floating-point coprocessor. It accepts one operation at a time over a valid/ready request channel, holds registered operands for a fixed number of execute cycles, then returns the result to the owning requester over a valid/ready response channel. It sits between the coprocessor command decoders and the combinational float_pack functions.

## Interface
- LATENCY, 2, execute cycles between request acceptance and response valid; legal range 1..15
- clk  in  1  core clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  requester has an operation pending
- req0_ready / req1_ready  out  1  arbiter accepts the operation this cycle
- req0_op / req1_op  in  2  opcode: 00 add, 01 sub, 10 mul, 11 reserved
- req0_a, req0_b / req1_a, req1_b  in  float  operands, float_pack::float width
- rsp0_valid / rsp1_valid  out  1  result available for that requester
- rsp0_ready / rsp1_ready  in  1  requester consumes the result
- rsp_result  out  float  shared result bus, meaningful only with rspX_valid
- rsp_err  out  1  set with rspX_valid when the opcode was unsupported
- busy  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: grant computed combinationally. If exactly one reqX_valid, grant that one. If both, grant the requester not equal to last_grant. reqX_ready = (state==IDLE) && grant==X. Never are both readies high.
- On a handshake: latch op, a, b and owner; last_grant <= owner; cnt <= LATENCY-1; go to EXEC.
- EXEC: cnt decrements each cycle. When cnt==0: register the result and err, then go to DONE.
- Result function on the latched operands:
  - add: float_sub(a, {~b.signe, b.exposant, b.mantisse})
  - sub: float_sub(a, b)
  - mul: float_mul(a, b)
  - reserved: result 0, err 1
- DONE: rsp<owner>_valid=1, the other rspX_valid=0. Result and err are held stable until rsp<owner>_ready. On the handshake, go to IDLE.
- Requester inputs may change freely outside their handshake cycle. The other requester's rsp_ready is ignored.
- Reset (any state, including mid-EXEC or DONE):
  - state IDLE, last_grant=1 (requester 0 wins the first tie), cnt=0
  - rsp_result=0, rsp_err=0
  - all readies, rsp valids and busy are 0 during reset
  - any in-flight operation is discarded with no response.

## Timing
- Request handshake at edge T: busy=1 from T; rsp_valid rises after edge T+LATENCY.
- With rsp_ready held high, the next request handshake can occur at edge T+LATENCY+2 at the earliest, because there is one IDLE cycle after the response handshake.
- Grant is re-evaluated every IDLE cycle. If a requester drops valid before its ready, nothing is accepted.
- A requester may hold rsp_ready low indefinitely; the arbiter stalls in DONE and both req_ready stay 0.

## Configuration
- FLOAT_COPRO_MUL_EN defined: opcode 10 computes float_mul and returns err=0.
- FLOAT_COPRO_MUL_EN not defined: float_mul is not instantiated. Opcode 10 is treated as reserved and returns result 0, err=1. Timing is unchanged.

## Structure
- float_pack adds:
  - typedef enum logic [1:0] fop_t {FOP_ADD, FOP_SUB, FOP_MUL, FOP_RSV}
  - typedef struct packed fop_req_t {fop_t op; float a; float b}
  - function float float_neg(float)
- One sub-module, float_copro_alu: purely combinational, maps (fop_t, a, b) to (result, err). It holds the FLOAT_COPRO_MUL_EN switch.
- The arbiter holds the FSM, counter, grant logic and output registers.

## Test plan
All scenarios use N_exposant=8, N_mantisse=23 and LATENCY=2.
- req0 add 0x3F800000 + 0x40000000 -> rsp0_valid after edge T+2, rsp_result 0x40400000, err 0.
- req1 sub 0x40A00000 - 0x40400000 -> rsp1_valid only, rsp_result 0x40000000.
- Mul 0x3FC00000 * 0x40000000:
  - with FLOAT_COPRO_MUL_EN -> 0x40400000, err 0
  - without it -> 0x00000000, err 1
- Both valid continuously for 4 ops -> grants go 0,1,0,1; each ready is a single cycle; ops are separated by LATENCY+2 edges with rsp_ready held high.
- Hold rsp0_ready low for 10 cycles while req1_valid=1 -> result stable, req1_ready stays 0, busy stays 1; req1 is accepted 2 cycles after rsp0_ready.
- Assert reset_n=0 during EXEC -> busy, ready and rsp_valid go 0 immediately; after release, a tie is granted to req0.

Source files
------------

// File: rtl/float_pack.sv
// Single-precision style float type plus combinational add/sub/mul helpers and
// the opcode/request types shared by the coprocessor arbiter.
package float_pack;

  localparam int N_exposant = 8;
  localparam int N_mantisse = 23;
  localparam int BIAS       = (1 << (N_exposant - 1)) - 1;
  localparam logic [N_exposant-1:0] EXP_MAX = '1;

  typedef struct packed {
    logic                  signe;
    logic [N_exposant-1:0] exposant;
    logic [N_mantisse-1:0] mantisse;
  } float;

  typedef enum logic [1:0] {FOP_ADD, FOP_SUB, FOP_MUL, FOP_RSV} fop_t;

  typedef struct packed {
    fop_t op;
    float a;
    float b;
  } fop_req_t;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} arb_state_t;

  function automatic float float_neg(input float x);
    float r;
    r = x;
    r.signe = ~x.signe;
    return r;
  endfunction

  // a - b on normal numbers; zero exponent is treated as zero, results truncate.
  function automatic float float_sub(input float a, input float b);
    float                  bn, big, sml, r;
    logic [N_mantisse+4:0] mb, ms, sum;
    logic [N_exposant-1:0] diff;
    int                    e, lz;
    logic                  found;
    bn = float_neg(b);
    if (a.exposant == '0) return bn;
    if (b.exposant == '0) return a;
    if ({a.exposant, a.mantisse} >= {bn.exposant, bn.mantisse}) begin
      big = a;
      sml = bn;
    end else begin
      big = bn;
      sml = a;
    end
    diff = big.exposant - sml.exposant;
    mb   = {2'b01, big.mantisse, 3'b000};
    ms   = {2'b01, sml.mantisse, 3'b000};
    ms   = (int'(diff) > N_mantisse + 4) ? '0 : (ms >> diff);
    sum  = (big.signe == sml.signe) ? (mb + ms) : (mb - ms);
    if (sum == '0) return '0;
    e = int'(big.exposant);
    if (sum[N_mantisse+4]) begin
      sum = sum >> 1;
      e   = e + 1;
    end else begin
      lz    = 0;
      found = 1'b0;
      for (int i = N_mantisse + 3; i >= 0; i--) begin
        if (!found && sum[i]) begin
          lz    = N_mantisse + 3 - i;
          found = 1'b1;
        end
      end
      sum = sum << lz;
      e   = e - lz;
    end
    r       = '0;
    r.signe = big.signe;
    if (e >= int'(EXP_MAX)) begin
      r.exposant = EXP_MAX;
    end else if (e > 0) begin
      r.exposant = e[N_exposant-1:0];
      r.mantisse = sum[N_mantisse+2:3];
    end else begin
      r = '0;
    end
    return r;
  endfunction

  function automatic float float_mul(input float a, input float b);
    float                    r;
    logic [2*N_mantisse+1:0] p;
    int                      e;
    r       = '0;
    r.signe = a.signe ^ b.signe;
    if (a.exposant == '0 || b.exposant == '0) return r;
    p = {{(N_mantisse+1){1'b0}}, 1'b1, a.mantisse} *
        {{(N_mantisse+1){1'b0}}, 1'b1, b.mantisse};
    e = int'(a.exposant) + int'(b.exposant) - BIAS;
    if (p[2*N_mantisse+1]) begin
      e          = e + 1;
      r.mantisse = p[2*N_mantisse:N_mantisse+1];
    end else begin
      r.mantisse = p[2*N_mantisse-1:N_mantisse];
    end
    if (e >= int'(EXP_MAX)) begin
      r.exposant = EXP_MAX;
      r.mantisse = '0;
    end else if (e > 0) begin
      r.exposant = e[N_exposant-1:0];
    end else begin
      r.exposant = '0;
      r.mantisse = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/float_copro_alu.sv
// Combinational opcode decoder in front of the float_pack functions.
// FLOAT_COPRO_MUL_EN enables the multiplier; otherwise mul behaves as reserved.
module float_copro_alu
  import float_pack::*;
(
  input  fop_t op,
  input  float a,
  input  float b,
  output float result,
  output logic err
);

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      FOP_ADD: result = float_sub(a, float_neg(b));
      FOP_SUB: result = float_sub(a, b);
`ifdef FLOAT_COPRO_MUL_EN
      FOP_MUL: result = float_mul(a, b);
`else
      FOP_MUL: err = 1'b1;
`endif
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/float_copro_arbiter.sv
// Round-robin arbiter sharing one float ALU between two requesters, with a
// fixed LATENCY execute phase. Mul support follows FLOAT_COPRO_MUL_EN.
module float_copro_arbiter
  import float_pack::*;
#(
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [1:0] req0_op,
  input  float       req0_a,
  input  float       req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [1:0] req1_op,
  input  float       req1_a,
  input  float       req1_b,
  output logic       rsp0_valid,
  output logic       rsp1_valid,
  input  logic       rsp0_ready,
  input  logic       rsp1_ready,
  output float       rsp_result,
  output logic       rsp_err,
  output logic       busy
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  arb_state_t state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_grant_q, last_grant_d;
  logic [3:0] cnt_q, cnt_d;
  fop_req_t   req_q, req_d;
  float       result_q, result_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;
  logic       rsp0_valid_q, rsp0_valid_d;
  logic       rsp1_valid_q, rsp1_valid_d;

  logic       grant;
  fop_req_t   pkt0, pkt1;
  float       alu_result;
  logic       alu_err;

  assign pkt0 = '{op: fop_t'(req0_op), a: req0_a, b: req0_b};
  assign pkt1 = '{op: fop_t'(req1_op), a: req1_a, b: req1_b};

  float_copro_alu u_alu (
    .op     (req_q.op),
    .a      (req_q.a),
    .b      (req_q.b),
    .result (alu_result),
    .err    (alu_err)
  );

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else if (req1_valid)          grant = 1'b1;
  end

  // Readies are gated by reset_n so nothing looks accepted while reset is held.
  assign req0_ready = reset_n && (state_q == S_IDLE) && req0_valid && !grant;
  assign req1_ready = reset_n && (state_q == S_IDLE) && req1_valid &&  grant;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    result_d     = result_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        if (req0_ready || req1_ready) begin
          req_d        = grant ? pkt1 : pkt0;
          owner_d      = grant;
          last_grant_d = grant;
          cnt_d        = CNT_INIT;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'd0) begin
          result_d = alu_result;
          err_d    = alu_err;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (owner_q ? rsp1_ready : rsp0_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d       = (state_d != S_IDLE);
    rsp0_valid_d = (state_d == S_DONE) && !owner_d;
    rsp1_valid_d = (state_d == S_DONE) &&  owner_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      req_q        <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      result_q     <= result_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  assign rsp_result = result_q;
  assign rsp_err    = err_q;
  assign busy       = busy_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;

endmodule
